// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch target buffer: control-flow opcodes,
// the predictability filter and counter initial values on allocation.
package branch_pred_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Allocation values, weakly taken (MSB only) and strongly taken (all ones),
    // expressed for any counter width up to 31 bits.
    localparam int unsigned CNT_INIT_WEAK_SHIFT_OFFSET = 1;

    function automatic logic [31:0] cnt_init_weak(int unsigned bits);
        return 32'(1) << (bits - CNT_INIT_WEAK_SHIFT_OFFSET);
    endfunction

    function automatic logic [31:0] cnt_init_strong(int unsigned bits);
        return (32'(1) << bits) - 32'(1);
    endfunction

    // JALR targets come from a register, so only BRANCH and JAL are tracked.
    function automatic logic is_predictable(logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JAL);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter with a synchronous load, one per BTB entry.
module bp_sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_inc,
    input  logic                i_dec,
    input  logic                i_load,
    input  logic [CNT_BITS-1:0] i_load_val,
    output logic [CNT_BITS-1:0] o_q
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] q_q;
    logic [CNT_BITS-1:0] q_d;

    // NOTE: q_d gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (i_load) begin
            q_d = i_load_val;
        end else if (i_inc && (q_q != CNT_MAX)) begin
            q_d = q_q + CNT_BITS'(1);
        end else if (i_dec && (q_q != '0)) begin
            q_d = q_q - CNT_BITS'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Fully-associative BTB with per-entry saturating direction counters,
// round-robin allocation and saturating lookup/mispredict statistics.
module branch_predictor_btb
    import branch_pred_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 8,
    parameter int CNT_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lookup_valid,
    input  logic [DATA_WIDTH-1:0] i_lookup_pc,
    input  logic [6:0]            i_lookup_opcode,
    output logic                  o_prediction,
    output logic [DATA_WIDTH-1:0] o_branch_target,
    output logic                  o_hit,
    input  logic                  i_update_valid,
    input  logic [DATA_WIDTH-1:0] i_update_pc,
    input  logic [6:0]            i_update_opcode,
    input  logic                  i_update_taken,
    input  logic [DATA_WIDTH-1:0] i_update_target,
    input  logic                  i_update_predicted,
    input  logic [DATA_WIDTH-1:0] i_update_pred_tgt,
    output logic                  o_mispredict,
    output logic                  o_restore_seq,
    output logic [STAT_WIDTH-1:0] o_lookup_cnt,
    output logic [STAT_WIDTH-1:0] o_mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0]   CNT_INIT_WEAK   = CNT_BITS'(cnt_init_weak(CNT_BITS));
    localparam logic [CNT_BITS-1:0]   CNT_INIT_STRONG = CNT_BITS'(cnt_init_strong(CNT_BITS));
    localparam logic [STAT_WIDTH-1:0] STAT_MAX        = '1;

    logic [ENTRIES-1:0]    valid_q, valid_d;
    logic [DATA_WIDTH-1:0] tag_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tag_d [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_q [ENTRIES];
    logic [DATA_WIDTH-1:0] tgt_d [ENTRIES];
    logic [CNT_BITS-1:0]   cnt_q [ENTRIES];
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [STAT_WIDTH-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [STAT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

    logic             lk_hit, up_hit;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic             lookup_elig, upd_elig, upd_en, train_taken, is_jal;
    logic             mispredict_raw;
    logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;
    logic [CNT_BITS-1:0] cnt_load_val;

    // Lowest matching index wins on both ports.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!lk_hit && valid_q[i] && (tag_q[i] == i_lookup_pc)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (!up_hit && valid_q[i] && (tag_q[i] == i_update_pc)) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
        end
    end

    assign lookup_elig  = is_predictable(i_lookup_opcode);
    assign upd_elig     = is_predictable(i_update_opcode);
    assign upd_en       = i_update_valid & upd_elig;
    assign is_jal       = (i_update_opcode == OPC_JAL);
    assign train_taken  = i_update_taken | is_jal;
    assign cnt_load_val = is_jal ? CNT_INIT_STRONG : CNT_INIT_WEAK;

    assign o_hit           = lk_hit;
    assign o_prediction    = i_lookup_valid & lookup_elig & lk_hit & cnt_q[lk_idx][CNT_BITS-1];
    assign o_branch_target = o_prediction ? tgt_q[lk_idx] : '0;

    assign mispredict_raw = upd_en &
                            ((i_update_taken != i_update_predicted) |
                             (i_update_taken & i_update_predicted &
                              (i_update_target != i_update_pred_tgt)));
    // Gated so every output reads zero while reset is held, whatever the pipe drives.
    assign o_mispredict  = i_rst_n & mispredict_raw;
    assign o_restore_seq = i_rst_n & i_update_valid & i_update_predicted & ~i_update_taken;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        assign cnt_inc[g]  = upd_en & up_hit & (up_idx == IDX_W'(g)) & train_taken;
        assign cnt_dec[g]  = upd_en & up_hit & (up_idx == IDX_W'(g)) & ~train_taken;
        assign cnt_load[g] = upd_en & ~up_hit & train_taken & (rr_q == IDX_W'(g));

        bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_ctr (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_inc      (cnt_inc[g]),
            .i_dec      (cnt_dec[g]),
            .i_load     (cnt_load[g]),
            .i_load_val (cnt_load_val),
            .o_q        (cnt_q[g])
        );
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        rr_d    = rr_q;
        if (upd_en && up_hit) begin
            if (train_taken) begin
                tgt_d[up_idx] = i_update_target;
            end
        end else if (upd_en && train_taken) begin
            valid_d[rr_q] = 1'b1;
            tag_d[rr_q]   = i_update_pc;
            tgt_d[rr_q]   = i_update_target;
            rr_d          = rr_q + IDX_W'(1);
        end
    end

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        misp_cnt_d   = misp_cnt_q;
        if (i_lookup_valid && lookup_elig && (lookup_cnt_q != STAT_MAX)) begin
            lookup_cnt_d = lookup_cnt_q + STAT_WIDTH'(1);
        end
        if (mispredict_raw && (misp_cnt_q != STAT_MAX)) begin
            misp_cnt_d = misp_cnt_q + STAT_WIDTH'(1);
        end
    end

    // NOTE: tag/target arrays are flops and are reset so a post-reset lookup can never
    // match stale data or leak a stale target; a RAM-backed table would not be reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= '0;
            rr_q         <= '0;
            lookup_cnt_q <= '0;
            misp_cnt_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            tgt_q        <= tgt_d;
            rr_q         <= rr_d;
            lookup_cnt_q <= lookup_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    assign o_lookup_cnt     = lookup_cnt_q;
    assign o_mispredict_cnt = misp_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios plus a
// randomized run scored against a table-level behavioural model.
module tb_branch_predictor_btb;

    localparam int N     = 8;
    localparam int CB    = 2;
    localparam int SW    = 8;
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CHALF = 1 << (CB - 1);
    localparam int SMAX  = (1 << SW) - 1;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lv, uv, ut, upr;
    logic [31:0] lpc, upc, utgt, uptgt;
    logic [6:0]  lop, uop;
    logic        o_prediction, o_hit, o_mispredict, o_restore_seq;
    logic [31:0] o_branch_target;
    logic [SW-1:0] o_lookup_cnt, o_mispredict_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a table of (valid, tag, target, counter value) plus stats.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    int          m_rr, m_lk, m_mp;

    always #5 clk = ~clk;

    branch_predictor_btb #(
        .DATA_WIDTH (32),
        .ENTRIES    (N),
        .CNT_BITS   (CB),
        .STAT_WIDTH (SW)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_lookup_valid     (lv),
        .i_lookup_pc        (lpc),
        .i_lookup_opcode    (lop),
        .o_prediction       (o_prediction),
        .o_branch_target    (o_branch_target),
        .o_hit              (o_hit),
        .i_update_valid     (uv),
        .i_update_pc        (upc),
        .i_update_opcode    (uop),
        .i_update_taken     (ut),
        .i_update_target    (utgt),
        .i_update_predicted (upr),
        .i_update_pred_tgt  (uptgt),
        .o_mispredict       (o_mispredict),
        .o_restore_seq      (o_restore_seq),
        .o_lookup_cnt       (o_lookup_cnt),
        .o_mispredict_cnt   (o_mispredict_cnt)
    );

    function automatic bit elig(logic [6:0] op);
        return (op == BR) || (op == JAL);
    endfunction

    function automatic int find(logic [31:0] pc);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && (m_tag[i] == pc)) return i;
        end
        return -1;
    endfunction

    function automatic bit exp_pred();
        int k = find(lpc);
        return lv && elig(lop) && (k >= 0) && (m_cnt[k] >= CHALF);
    endfunction

    function automatic logic [31:0] exp_tgt();
        int k = find(lpc);
        return exp_pred() ? m_tgt[k] : 32'h0;
    endfunction

    function automatic bit exp_misp();
        return uv && elig(uop) && ((ut != upr) || (ut && upr && (utgt != uptgt)));
    endfunction

    function automatic bit exp_rest();
        return uv && upr && !ut;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 0;
        end
        m_rr = 0;
        m_lk = 0;
        m_mp = 0;
    endtask

    task automatic model_step();
        bit t;
        int k;
        if (lv && elig(lop) && (m_lk < SMAX)) m_lk++;
        if (exp_misp() && (m_mp < SMAX)) m_mp++;
        if (uv && elig(uop)) begin
            t = ut || (uop == JAL);
            k = find(upc);
            if (k >= 0) begin
                if (t) begin
                    m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
                    m_tgt[k] = utgt;
                end else begin
                    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
                end
            end else if (t) begin
                m_valid[m_rr] = 1'b1;
                m_tag[m_rr]   = upc;
                m_tgt[m_rr]   = utgt;
                m_cnt[m_rr]   = (uop == JAL) ? CMAX : CHALF;
                m_rr          = (m_rr + 1) % N;
            end
        end
    endtask

    task automatic idle();
        lv = 1'b0; lpc = '0; lop = '0;
        uv = 1'b0; upc = '0; uop = '0; ut = 1'b0; utgt = '0; upr = 1'b0; uptgt = '0;
    endtask

    task automatic set_lookup(logic v, logic [31:0] pc, logic [6:0] op);
        lv = v; lpc = pc; lop = op;
    endtask

    task automatic set_update(logic v, logic [31:0] pc, logic [6:0] op, logic t,
                              logic [31:0] tgt, logic p, logic [31:0] ptgt);
        uv = v; upc = pc; uop = op; ut = t; utgt = tgt; upr = p; uptgt = ptgt;
    endtask

    // Advance one clock: the model consumes the inputs the DUT is about to sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== 34'h0) begin
            bad++;
            $display("FAIL reset_lookup: hit/pred/tgt got %0b/%0b/%h want 0/0/0", o_hit, o_prediction, o_branch_target);
        end
        total++;
        if ({o_lookup_cnt, o_mispredict_cnt, o_mispredict, o_restore_seq} !== '0) begin
            bad++;
            $display("FAIL reset_stats: lk=%0d mp=%0d misp=%0b rest=%0b want all 0", o_lookup_cnt, o_mispredict_cnt, o_mispredict, o_restore_seq);
        end
        tick();
    endtask

    task automatic test_train();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b1, 32'h400040, 1'b0, 32'h0);
        #1;
        total++;
        if ({o_mispredict, o_restore_seq} !== 2'b10) begin
            bad++;
            $display("FAIL first_update: misp/rest got %0b/%0b want 1/0", o_mispredict, o_restore_seq);
        end
        tick();
        idle();
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== {1'b1, 1'b1, 32'h400040}) begin
            bad++;
            $display("FAIL alloc_lookup: hit/pred/tgt got %0b/%0b/%h want 1/1/00400040", o_hit, o_prediction, o_branch_target);
        end
        tick();
    endtask

    task automatic test_counter();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b0, 32'h0, 1'b1, 32'h400040);
        #1;
        total++;
        if ({o_mispredict, o_restore_seq} !== 2'b11) begin
            bad++;
            $display("FAIL nt_restore: misp/rest got %0b/%0b want 1/1", o_mispredict, o_restore_seq);
        end
        tick();
        idle();
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL ctr_01: hit/pred/tgt got %0b/%0b/%h want 1/0/0", o_hit, o_prediction, o_branch_target);
        end
        tick();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        total++;
        if (o_mispredict !== 1'b0) begin
            bad++;
            $display("FAIL nt_correct: misp got %0b want 0", o_mispredict);
        end
        tick();
        tick();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b1, 32'h400040, 1'b0, 32'h0);
        tick();
        idle();
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if (o_prediction !== 1'b0) begin
            bad++;
            $display("FAIL ctr_floor: pred got %0b want 0 (counter must hold at 0)", o_prediction);
        end
        tick();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b1, 32'h400040, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        idle();
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if ({o_prediction, o_branch_target} !== {1'b1, 32'h400040}) begin
            bad++;
            $display("FAIL ctr_sat: pred/tgt got %0b/%h want 1/00400040", o_prediction, o_branch_target);
        end
        tick();
        idle();
        set_update(1'b1, 32'h400010, BR, 1'b0, 32'h0, 1'b1, 32'h400040);
        tick();
        idle();
        set_lookup(1'b1, 32'h400010, BR);
        #1;
        total++;
        if (o_prediction !== 1'b1) begin
            bad++;
            $display("FAIL ctr_ceiling: pred got %0b want 1 (11 minus one)", o_prediction);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i <= N; i++) begin
            set_update(1'b1, 32'h400000 + 32'(4 * i), BR, 1'b1, 32'h500000 + 32'(16 * i), 1'b0, 32'h0);
            tick();
        end
        idle();
        for (int i = 0; i <= N; i++) begin
            logic [31:0] want_tgt;
            logic        want_hit;
            want_hit = (i != 0);
            want_tgt = want_hit ? 32'h500000 + 32'(16 * i) : 32'h0;
            set_lookup(1'b1, 32'h400000 + 32'(4 * i), BR);
            #1;
            total++;
            if ({o_hit, o_prediction, o_branch_target} !== {want_hit, want_hit, want_tgt}) begin
                bad++;
                $display("FAIL wrap_entry%0d: hit/pred/tgt got %0b/%0b/%h want %0b/%0b/%h",
                         i, o_hit, o_prediction, o_branch_target, want_hit, want_hit, want_tgt);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        idle();
        set_lookup(1'b1, 32'h400080, BR);
        set_update(1'b1, 32'h400080, BR, 1'b1, 32'h400800, 1'b0, 32'h0);
        #1;
        total++;
        if ({o_hit, o_prediction, o_mispredict} !== 3'b001) begin
            bad++;
            $display("FAIL same_cycle: hit/pred/misp got %0b/%0b/%0b want 0/0/1", o_hit, o_prediction, o_mispredict);
        end
        tick();
        idle();
        set_lookup(1'b1, 32'h400080, BR);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== {1'b1, 1'b1, 32'h400800}) begin
            bad++;
            $display("FAIL next_cycle: hit/pred/tgt got %0b/%0b/%h want 1/1/00400800", o_hit, o_prediction, o_branch_target);
        end
        tick();
        idle();
        set_update(1'b1, 32'h400100, JALR, 1'b1, 32'h400900, 1'b0, 32'h0);
        #1;
        total++;
        if (o_mispredict !== 1'b0) begin
            bad++;
            $display("FAIL jalr_misp: got %0b want 0", o_mispredict);
        end
        tick();
        idle();
        set_lookup(1'b1, 32'h400100, BR);
        #1;
        total++;
        if (o_hit !== 1'b0) begin
            bad++;
            $display("FAIL jalr_alloc: hit got %0b want 0", o_hit);
        end
        tick();
        idle();
        set_update(1'b1, 32'h400200, JAL, 1'b1, 32'h400a00, 1'b0, 32'h0);
        tick();
        idle();
        set_update(1'b1, 32'h400200, JAL, 1'b1, 32'h400a00, 1'b1, 32'h400a00);
        tick();
        idle();
        set_lookup(1'b1, 32'h400200, JAL);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== {1'b1, 1'b1, 32'h400a00}) begin
            bad++;
            $display("FAIL jal_lookup: hit/pred/tgt got %0b/%0b/%h want 1/1/00400a00", o_hit, o_prediction, o_branch_target);
        end
        tick();
        set_lookup(1'b1, 32'h400200, JALR);
        #1;
        total++;
        if ({o_hit, o_prediction, o_branch_target} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL jalr_lookup: hit/pred/tgt got %0b/%0b/%h want 1/0/0", o_hit, o_prediction, o_branch_target);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ALU;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            lv    = ($urandom_range(0, 3) != 0);
            lpc   = 32'h1000 + 32'(4 * $urandom_range(0, 11));
            lop   = ops[$urandom_range(0, 3)];
            uv    = ($urandom_range(0, 3) != 0);
            upc   = 32'h1000 + 32'(4 * $urandom_range(0, 11));
            uop   = ops[$urandom_range(0, 3)];
            ut    = 1'($urandom_range(0, 1));
            utgt  = 32'h8000 + 32'(4 * $urandom_range(0, 3));
            upr   = 1'($urandom_range(0, 1));
            uptgt = ($urandom_range(0, 2) != 0) ? utgt : 32'h8000 + 32'(4 * $urandom_range(0, 3));
            #1;
            total++;
            if (o_hit !== (find(lpc) >= 0)) begin
                bad++;
                $display("FAIL rnd_hit[%0d]: got %0b want %0b", n, o_hit, (find(lpc) >= 0));
            end
            total++;
            if ({o_prediction, o_branch_target} !== {exp_pred(), exp_tgt()}) begin
                bad++;
                $display("FAIL rnd_pred[%0d]: pred/tgt got %0b/%h want %0b/%h", n, o_prediction, o_branch_target, exp_pred(), exp_tgt());
            end
            total++;
            if ({o_mispredict, o_restore_seq} !== {exp_misp(), exp_rest()}) begin
                bad++;
                $display("FAIL rnd_misp[%0d]: misp/rest got %0b/%0b want %0b/%0b", n, o_mispredict, o_restore_seq, exp_misp(), exp_rest());
            end
            total++;
            if ({o_lookup_cnt, o_mispredict_cnt} !== {SW'(m_lk), SW'(m_mp)}) begin
                bad++;
                $display("FAIL rnd_stats[%0d]: lk/mp got %0d/%0d want %0d/%0d", n, o_lookup_cnt, o_mispredict_cnt, m_lk, m_mp);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_stats();
        do_reset();
        set_update(1'b1, 32'h7000, BR, 1'b0, 32'h0, 1'b1, 32'h7040);
        #1;
        total++;
        if ({o_mispredict, o_restore_seq} !== 2'b11) begin
            bad++;
            $display("FAIL stat_restore: misp/rest got %0b/%0b want 1/1", o_mispredict, o_restore_seq);
        end
        tick();
        total++;
        if (o_mispredict_cnt !== SW'(1)) begin
            bad++;
            $display("FAIL stat_inc: mispredict_cnt got %0d want 1", o_mispredict_cnt);
        end
        set_lookup(1'b1, 32'h7000, BR);
        for (int i = 0; i < SMAX + 40; i++) tick();
        total++;
        if ({o_lookup_cnt, o_mispredict_cnt} !== {SW'(SMAX), SW'(SMAX)}) begin
            bad++;
            $display("FAIL stat_sat: lk/mp got %0d/%0d want %0d/%0d", o_lookup_cnt, o_mispredict_cnt, SMAX, SMAX);
        end
        idle();
        set_update(1'b1, 32'h7100, BR, 1'b1, 32'h7200, 1'b0, 32'h0);
        tick();
        set_lookup(1'b1, 32'h7100, BR);
        set_update(1'b1, 32'h7100, BR, 1'b0, 32'h0, 1'b1, 32'h7200);
        #1;
        total++;
        if ({o_hit, o_prediction, o_restore_seq, o_mispredict} !== 4'b1111) begin
            bad++;
            $display("FAIL pre_reset: hit/pred/rest/misp got %0b/%0b/%0b/%0b want 1/1/1/1", o_hit, o_prediction, o_restore_seq, o_mispredict);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({o_prediction, o_branch_target, o_hit, o_mispredict, o_restore_seq, o_lookup_cnt, o_mispredict_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset: pred=%0b tgt=%h hit=%0b misp=%0b rest=%0b lk=%0d mp=%0d want all 0",
                     o_prediction, o_branch_target, o_hit, o_mispredict, o_restore_seq, o_lookup_cnt, o_mispredict_cnt);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        set_lookup(1'b1, 32'h7100, BR);
        #1;
        total++;
        if ({o_hit, o_prediction} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset: hit/pred got %0b/%0b want 0/0", o_hit, o_prediction);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_train();
        test_counter();
        test_wrap();
        test_same_cycle();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
